dmem_responder: RTL and testbench

Data-side memory responder: the block that answers the memory1-stage load/store requests and produces the load_data / load_data_addr / load_data_valid return consumed by the memory/writeback pipe. It holds a one-entry posted-write buffer with store-to-load forwarding, and issues reads and buffered writes to main memory over a valid/ready request port with a separate response strobe. Its stall output drives the pipeline's stall_mem.

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_write_buffer.sv | 52 +++++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-side memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH        = DMEM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WB_DRAIN = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_write_buffer.sv
// Single-entry posted-write buffer with word-address match flags.
module dmem_write_buffer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_BITS = 20
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fill,
    input  logic                      clear,
    input  logic [ADDRESS_BITS-1:0]   fill_addr,
    input  logic [DATA_WIDTH-1:0]     fill_data,
    input  logic [DATA_WIDTH/8-1:0]   fill_be,
    input  logic [ADDRESS_BITS-3:0]   req_word,
    output logic                      wb_valid,
    output logic [ADDRESS_BITS-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [DATA_WIDTH/8-1:0]   wb_be,
    output logic                      full_match,
    output logic                      partial_match
);

    logic word_match;
    logic be_full;

    // Entry storage: fill takes precedence, clear retires the drained write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_be    <= '0;
        end else if (fill) begin
            wb_valid <= 1'b1;
            wb_addr  <= fill_addr;
            wb_data  <= fill_data;
            wb_be    <= fill_be;
        end else if (clear) begin
            wb_valid <= 1'b0;
        end
    end

    // Match flags against the presented request's word address.
    always_comb begin
        word_match    = (req_word == wb_addr[ADDRESS_BITS-1:2]);
        be_full       = &wb_be;
        full_match    = wb_valid & word_match & be_full;
        partial_match = wb_valid & word_match & ~be_full;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: load/store acceptance, store-to-load
// forwarding from a posted-write buffer, and the main-memory request port.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_BITS = 20
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [ADDRESS_BITS-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_en,
    output logic                      req_ready,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     load_data,
    output logic [ADDRESS_BITS-1:0]   load_data_addr,
    output logic                      load_data_valid,
    output logic                      mem_req_valid,
    output logic                      mem_req_write,
    output logic [ADDRESS_BITS-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data
);

    dmem_state_e               state, next_state;
    logic [ADDRESS_BITS-1:0]   rd_addr;

    logic                      wb_fill, wb_clear;
    logic                      wb_valid;
    logic [ADDRESS_BITS-1:0]   wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [DATA_WIDTH/8-1:0]   wb_be;
    logic                      full_match, partial_match;

    logic                      fwd_fire, miss_fire, rsp_fire;

    dmem_write_buffer #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_wbuf (
        .clock         (clock),
        .reset         (reset),
        .fill          (wb_fill),
        .clear         (wb_clear),
        .fill_addr     (req_addr),
        .fill_data     (req_wdata),
        .fill_be       (req_byte_en),
        .req_word      (req_addr[ADDRESS_BITS-1:2]),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_be         (wb_be),
        .full_match    (full_match),
        .partial_match (partial_match)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, acceptance and memory-port drive.
    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        wb_fill       = 1'b0;
        wb_clear      = 1'b0;
        fwd_fire      = 1'b0;
        miss_fire     = 1'b0;
        rsp_fire      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_byte_en   = '0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid && req_write && !wb_valid) begin
                    req_ready = 1'b1;
                    wb_fill   = 1'b1;
                end else if (req_valid && !req_write && !partial_match) begin
                    // Loads win over the drain; a partial match is excluded
                    // above so it falls through to the drain branch.
                    req_ready = 1'b1;
                    if (full_match) begin
                        fwd_fire = 1'b1;
                    end else begin
                        miss_fire  = 1'b1;
                        next_state = ST_RD_ISSUE;
                    end
                end else if (wb_valid) begin
                    next_state = ST_WB_DRAIN;
                end
            end
            ST_RD_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_addr      = rd_addr;
                mem_byte_en   = '1;
                if (mem_req_ready) begin
                    next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_fire   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_WB_DRAIN: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_addr      = wb_addr;
                mem_wdata     = wb_data;
                mem_byte_en   = wb_be;
                if (mem_req_ready) begin
                    wb_clear   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb stall = req_valid & ~req_ready;

    // Load return register and latched miss address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_data       <= '0;
            load_data_addr  <= '0;
            load_data_valid <= 1'b0;
            rd_addr         <= '0;
        end else begin
            load_data_valid <= 1'b0;
            if (fwd_fire) begin
                load_data       <= wb_data;
                load_data_addr  <= req_addr;
                load_data_valid <= 1'b1;
            end else if (rsp_fire) begin
                load_data       <= mem_rsp_data;
                load_data_addr  <= rd_addr;
                load_data_valid <= 1'b1;
            end
            if (miss_fire) begin
                rd_addr <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DW = DMEM_DATA_WIDTH;
    localparam int unsigned AW = 20;
    localparam int unsigned BW = BE_WIDTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_byte_en;
    logic          req_ready, stall;
    logic [DW-1:0] load_data;
    logic [AW-1:0] load_data_addr;
    logic          load_data_valid;
    logic          mem_req_valid, mem_req_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_byte_en;
    logic          mem_req_ready, mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    dmem_responder #(
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_byte_en     (req_byte_en),
        .req_ready       (req_ready),
        .stall           (stall),
        .load_data       (load_data),
        .load_data_addr  (load_data_addr),
        .load_data_valid (load_data_valid),
        .mem_req_valid   (mem_req_valid),
        .mem_req_write   (mem_req_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_en     (mem_byte_en),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_none();
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_byte_en = '0;
    endtask

    task automatic req_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = a;
        req_wdata   = d;
        req_byte_en = be;
    endtask

    task automatic req_load(input logic [AW-1:0] a);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = a;
        req_wdata   = '0;
        req_byte_en = '0;
    endtask

    initial begin
        reset         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        req_none();
        #2;
        chk("rst_ldv",       load_data_valid, 0);
        chk("rst_ld",        load_data, 0);
        chk("rst_lda",       load_data_addr, 0);
        chk("rst_memvalid",  mem_req_valid, 0);
        chk("rst_memaddr",   mem_addr, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Full-match forward
        req_store(20'h100, 32'hDEADBEEF, 4'hF);
        #1;
        chk("fwd_st_ready", req_ready, 1);
        chk("fwd_st_stall", stall, 0);
        tick();
        req_load(20'h100);
        #1;
        chk("fwd_ld_ready", req_ready, 1);
        chk("fwd_ld_memv",  mem_req_valid, 0);
        tick();
        req_none();
        #1;
        chk("fwd_ldv",  load_data_valid, 1);
        chk("fwd_ld",   load_data, 32'hDEADBEEF);
        chk("fwd_lda",  load_data_addr, 20'h100);
        chk("fwd_memv", mem_req_valid, 0);
        tick();
        #1;
        chk("drn1_memv",  mem_req_valid, 1);
        chk("drn1_write", mem_req_write, 1);
        chk("drn1_addr",  mem_addr, 20'h100);
        chk("drn1_data",  mem_wdata, 32'hDEADBEEF);
        chk("drn1_ldv",   load_data_valid, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;

        // Plain miss, minimum latency
        req_load(20'h040);
        #1;
        chk("miss_ready", req_ready, 1);
        tick();
        req_none();
        #1;
        chk("miss_memv",  mem_req_valid, 1);
        chk("miss_write", mem_req_write, 0);
        chk("miss_addr",  mem_addr, 20'h040);
        chk("miss_be",    mem_byte_en, 4'hF);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h12345678;
        #1;
        chk("miss_memv_wait", mem_req_valid, 0);
        chk("miss_ldv_early", load_data_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        chk("miss_ldv", load_data_valid, 1);
        chk("miss_ld",  load_data, 32'h12345678);
        chk("miss_lda", load_data_addr, 20'h040);
        tick();
        #1;
        chk("miss_ldv_pulse", load_data_valid, 0);
        chk("miss_ld_hold",   load_data, 32'h12345678);

        // Issue held off by mem_req_ready for 5 cycles
        req_load(20'h080);
        tick();
        req_load(20'h0C0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_memv",  mem_req_valid, 1);
            chk("hold_addr",  mem_addr, 20'h080);
            chk("hold_stall", stall, 1);
            chk("hold_ldv",   load_data_valid, 0);
            tick();
        end
        req_none();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFEF00D;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("hold_ldv_ret", load_data_valid, 1);
        chk("hold_ld",      load_data, 32'hCAFEF00D);
        chk("hold_lda",     load_data_addr, 20'h080);

        // Partial match stalls until drained, then misses to memory
        req_store(20'h200, 32'hAAAA5555, 4'b0011);
        tick();
        req_load(20'h200);
        #1;
        chk("part_stall", stall, 1);
        chk("part_ready", req_ready, 0);
        tick();
        #1;
        chk("part_drn_stall", stall, 1);
        chk("part_drn_write", mem_req_write, 1);
        chk("part_drn_addr",  mem_addr, 20'h200);
        chk("part_drn_be",    mem_byte_en, 4'b0011);
        chk("part_drn_data",  mem_wdata, 32'hAAAA5555);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("part_ready_after", req_ready, 1);
        chk("part_stall_after", stall, 0);
        tick();
        req_none();
        #1;
        chk("part_rd_memv",  mem_req_valid, 1);
        chk("part_rd_write", mem_req_write, 0);
        chk("part_rd_addr",  mem_addr, 20'h200);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h11223344;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("part_ldv", load_data_valid, 1);
        chk("part_ld",  load_data, 32'h11223344);
        chk("part_lda", load_data_addr, 20'h200);

        // Load to another word overtakes the pending drain
        req_store(20'h300, 32'h0BADF00D, 4'hF);
        tick();
        req_load(20'h304);
        #1;
        chk("ovt_ld_ready", req_ready, 1);
        chk("ovt_memv_idle", mem_req_valid, 0);
        tick();
        req_store(20'h308, 32'h01020304, 4'hF);
        #1;
        chk("ovt_rd_memv",  mem_req_valid, 1);
        chk("ovt_rd_write", mem_req_write, 0);
        chk("ovt_rd_addr",  mem_addr, 20'h304);
        chk("ovt_st_stall", stall, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h55667788;
        #1;
        chk("ovt_wait_stall", stall, 1);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("ovt_ldv",        load_data_valid, 1);
        chk("ovt_ld",         load_data, 32'h55667788);
        chk("ovt_lda",        load_data_addr, 20'h304);
        chk("ovt_idle_stall", stall, 1);
        chk("ovt_idle_memv",  mem_req_valid, 0);
        tick();
        #1;
        chk("ovt_drn_write", mem_req_write, 1);
        chk("ovt_drn_addr",  mem_addr, 20'h300);
        chk("ovt_drn_data",  mem_wdata, 32'h0BADF00D);
        chk("ovt_drn_stall", stall, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("ovt_st2_ready", req_ready, 1);
        tick();
        req_none();
        tick();
        #1;
        chk("ovt_drn2_addr", mem_addr, 20'h308);
        chk("ovt_drn2_data", mem_wdata, 32'h01020304);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;

        // Reset during RD_WAIT abandons the read
        req_load(20'h400);
        tick();
        req_none();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("rrst_ldv",  load_data_valid, 0);
        chk("rrst_ld",   load_data, 0);
        chk("rrst_lda",  load_data_addr, 0);
        chk("rrst_memv", mem_req_valid, 0);
        chk("rrst_addr", mem_addr, 0);
        tick();
        reset = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h99999999;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("rrst_late_ldv", load_data_valid, 0);
        chk("rrst_late_ld",  load_data, 0);
        req_load(20'h500);
        #1;
        chk("rrst_ready", req_ready, 1);
        chk("rrst_memv_idle", mem_req_valid, 0);
        req_none();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
